// File: rtl/m_axi_reg.sv
// Single-outstanding, single-beat AXI initiator that turns one register command into one AXI transaction.
// All interface outputs are registers owned by one FSM; IDs are the constant TXN_ID.
module m_axi_reg #(
    parameter logic [3:0] TXN_ID = 4'h0
) (
    input  logic        clk,
    input  logic        areset,

    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    input  logic [3:0]  cmd_wstrb_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_write_o,
    output logic [31:0] rsp_rdata_o,
    output logic [1:0]  rsp_resp_o,

    output logic [3:0]  awid_o,
    output logic [31:0] awaddr_o,
    output logic        awvalid_o,
    input  logic        awready_i,

    output logic [3:0]  wid_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        wlast_o,
    output logic        wvalid_o,
    input  logic        wready_i,

    input  logic [3:0]  bid_i,
    input  logic [1:0]  bresp_i,
    input  logic        bvalid_i,
    output logic        bready_o,

    output logic [3:0]  arid_o,
    output logic [31:0] araddr_o,
    output logic        arvalid_o,
    input  logic        arready_i,

    input  logic [3:0]  rid_i,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    input  logic        rlast_i,
    input  logic        rvalid_i,
    output logic        rready_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t      r_state;
    logic        r_cmd_ready;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_bready;
    logic        r_arvalid;
    logic        r_rready;
    logic        r_rsp_valid;
    logic        r_rsp_write;
    logic [31:0] r_rsp_rdata;
    logic [1:0]  r_rsp_resp;

    logic        w_aw_clear;
    logic        w_w_clear;
    logic [1:0]  w_b_code;
    logic [1:0]  w_r_code;

    // A malformed response (wrong ID or missing last) overrides whatever code the slave sent.
    function automatic logic [1:0] f_resp_code(input logic id_ok, input logic last_ok,
                                               input logic [1:0] resp);
        logic [1:0] code;
        if (id_ok && last_ok) begin
            code = resp;
        end else begin
            code = RESP_SLVERR;
        end
        return code;
    endfunction

    // Write-request completion per channel and the response codes that would be captured.
    always_comb begin
        w_aw_clear = 1'b0;
        w_w_clear  = 1'b0;
        w_b_code   = 2'b00;
        w_r_code   = 2'b00;
        if (r_awvalid) begin
            w_aw_clear = awready_i;
        end else begin
            w_aw_clear = 1'b1;
        end
        if (r_wvalid) begin
            w_w_clear = wready_i;
        end else begin
            w_w_clear = 1'b1;
        end
        w_b_code = f_resp_code(bid_i == TXN_ID, 1'b1, bresp_i);
        w_r_code = f_resp_code(rid_i == TXN_ID, rlast_i, rresp_i);
    end

    // Transaction FSM; every interface output is registered here.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= 32'h0000_0000;
            r_wdata     <= 32'h0000_0000;
            r_wstrb     <= 4'h0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
            r_rsp_resp  <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_cmd_ready && cmd_valid_i) begin
                        r_cmd_ready <= 1'b0;
                        r_write     <= cmd_write_i;
                        r_addr      <= cmd_addr_i;
                        r_wdata     <= cmd_wdata_i;
                        r_wstrb     <= cmd_wstrb_i;
                        if (cmd_write_i) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= WR_REQ;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= RD_REQ;
                        end
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                WR_REQ: begin
                    // AW and W retire independently; leave once neither is still pending.
                    if (w_aw_clear) begin
                        r_awvalid <= 1'b0;
                    end
                    if (w_w_clear) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_clear && w_w_clear) begin
                        r_bready <= 1'b1;
                        r_state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bvalid_i) begin
                        r_bready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_write <= r_write;
                        r_rsp_rdata <= 32'h0000_0000;
                        r_rsp_resp  <= w_b_code;
                        r_state     <= DONE;
                    end
                end
                RD_REQ: begin
                    if (arready_i) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (rvalid_i) begin
                        r_rready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_write <= r_write;
                        r_rsp_rdata <= rdata_i;
                        r_rsp_resp  <= w_r_code;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    // Ready is raised on the way out so IDLE can accept in its first cycle.
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cmd_ready <= 1'b0;
                    r_awvalid   <= 1'b0;
                    r_wvalid    <= 1'b0;
                    r_bready    <= 1'b0;
                    r_arvalid   <= 1'b0;
                    r_rready    <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o = r_cmd_ready;

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_write_o = r_rsp_write;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_resp_o  = r_rsp_resp;

    assign awid_o    = TXN_ID;
    assign awaddr_o  = r_addr;
    assign awvalid_o = r_awvalid;

    assign wid_o    = TXN_ID;
    assign wdata_o  = r_wdata;
    assign wstrb_o  = r_wstrb;
    assign wlast_o  = r_wvalid;
    assign wvalid_o = r_wvalid;

    assign bready_o = r_bready;

    assign arid_o    = TXN_ID;
    assign araddr_o  = r_addr;
    assign arvalid_o = r_arvalid;

    assign rready_o = r_rready;

endmodule

// File: tb/tb_m_axi_reg.sv
// Directed bench for m_axi_reg: hand-computed expectations checked with immediate assertions.
`timescale 1ns/1ps
module tb_m_axi_reg;

    logic        clk;
    logic        areset;
    logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
    logic [31:0] cmd_addr_i, cmd_wdata_i;
    logic [3:0]  cmd_wstrb_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_write_o;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_resp_o;
    logic [3:0]  awid_o, wid_o, arid_o, wstrb_o, bid_i, rid_i;
    logic [31:0] awaddr_o, wdata_o, araddr_o, rdata_i;
    logic        awvalid_o, awready_i, wlast_o, wvalid_o, wready_i;
    logic [1:0]  bresp_i, rresp_i;
    logic        bvalid_i, bready_o, arvalid_o, arready_i, rlast_i, rvalid_i, rready_o;

    int n_run  = 0;
    int n_fail = 0;

    m_axi_reg #(.TXN_ID(4'h0)) dut (
        .clk(clk), .areset(areset),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_wstrb_i(cmd_wstrb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_write_o(rsp_write_o),
        .rsp_rdata_o(rsp_rdata_o), .rsp_resp_o(rsp_resp_o),
        .awid_o(awid_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .arid_o(arid_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
        .rvalid_i(rvalid_i), .rready_o(rready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb);
        cmd_valid_i = 1'b1;
        cmd_write_i = wr;
        cmd_addr_i  = addr;
        cmd_wdata_i = data;
        cmd_wstrb_i = strb;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk({tag, "_rsp_valid_drop"}, {31'd0, rsp_valid_o}, 32'd0);
        chk({tag, "_cmd_ready_back"}, {31'd0, cmd_ready_o}, 32'd1);
    endtask

    initial begin
        areset = 1'b0;
        cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = 32'd0; cmd_wdata_i = 32'd0;
        cmd_wstrb_i = 4'h0; rsp_ready_i = 1'b0;
        awready_i = 1'b0; wready_i = 1'b0; arready_i = 1'b0;
        bid_i = 4'h0; bresp_i = 2'b00; bvalid_i = 1'b0;
        rid_i = 4'h0; rdata_i = 32'd0; rresp_i = 2'b00; rlast_i = 1'b0; rvalid_i = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
        chk("rst_valids", {27'd0, awvalid_o, wvalid_o, arvalid_o, rsp_valid_o, bready_o}, 32'd0);
        chk("rst_rready", {31'd0, rready_o}, 32'd0);
        chk("rst_awaddr", awaddr_o, 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
        chk("rst_ids", {20'd0, awid_o, wid_o, arid_o}, 32'd0);
        areset = 1'b1;
        tick();
        chk("post_rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);

        // Best-case write
        awready_i = 1'b1; wready_i = 1'b1;
        issue(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF);
        chk("w1_aw_w_valid", {30'd0, awvalid_o, wvalid_o}, 32'd3);
        chk("w1_wlast", {31'd0, wlast_o}, 32'd1);
        chk("w1_awaddr", awaddr_o, 32'h0000_0004);
        chk("w1_wdata", wdata_o, 32'hDEAD_BEEF);
        chk("w1_wstrb", {28'd0, wstrb_o}, 32'hF);
        chk("w1_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
        tick();
        awready_i = 1'b0; wready_i = 1'b0;
        chk("w1_valids_drop", {30'd0, awvalid_o, wvalid_o}, 32'd0);
        chk("w1_bready", {31'd0, bready_o}, 32'd1);
        chk("w1_no_rsp_early", {31'd0, rsp_valid_o}, 32'd0);
        bvalid_i = 1'b1; bid_i = 4'h0; bresp_i = 2'b00;
        tick();
        bvalid_i = 1'b0;
        chk("w1_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        chk("w1_rsp_resp", {30'd0, rsp_resp_o}, 32'd0);
        chk("w1_rsp_write", {31'd0, rsp_write_o}, 32'd1);
        chk("w1_rsp_rdata", rsp_rdata_o, 32'd0);
        chk("w1_bready_drop", {31'd0, bready_o}, 32'd0);
        finish_rsp("w1");

        // Write with W accepted 5 cycles after AW; stray B in WR_REQ must be ignored
        awready_i = 1'b1;
        issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'h3);
        tick();
        awready_i = 1'b0;
        chk("w2_aw_drop", {31'd0, awvalid_o}, 32'd0);
        chk("w2_w_held", {31'd0, wvalid_o}, 32'd1);
        bvalid_i = 1'b1; bresp_i = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("w2_w_hold_valid", {31'd0, wvalid_o}, 32'd1);
            chk("w2_w_hold_data", wdata_o, 32'hDEAD_BEEF);
            chk("w2_bready_low", {31'd0, bready_o}, 32'd0);
            chk("w2_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
        end
        wready_i = 1'b1; bvalid_i = 1'b0; bresp_i = 2'b00;
        tick();
        wready_i = 1'b0;
        chk("w2_w_drop", {31'd0, wvalid_o}, 32'd0);
        chk("w2_bready", {31'd0, bready_o}, 32'd1);
        chk("w2_stray_b_ignored", {31'd0, rsp_valid_o}, 32'd0);
        bvalid_i = 1'b1;
        tick();
        bvalid_i = 1'b0;
        chk("w2_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        chk("w2_rsp_resp", {30'd0, rsp_resp_o}, 32'd0);
        finish_rsp("w2");

        // Read with arready after 2 cycles; stray R during RD_REQ ignored
        issue(1'b0, 32'h0000_0008, 32'd0, 4'h0);
        chk("r1_arvalid", {31'd0, arvalid_o}, 32'd1);
        chk("r1_araddr", araddr_o, 32'h0000_0008);
        chk("r1_rready_low", {31'd0, rready_o}, 32'd0);
        rvalid_i = 1'b1; rdata_i = 32'hFFFF_0000; rlast_i = 1'b1;
        tick();
        rvalid_i = 1'b0;
        chk("r1_arvalid_held", {31'd0, arvalid_o}, 32'd1);
        chk("r1_stray_r_ignored", {31'd0, rsp_valid_o}, 32'd0);
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        chk("r1_arvalid_drop", {31'd0, arvalid_o}, 32'd0);
        chk("r1_rready", {31'd0, rready_o}, 32'd1);
        rvalid_i = 1'b1; rdata_i = 32'h1234_5678; rresp_i = 2'b00; rid_i = 4'h0; rlast_i = 1'b1;
        tick();
        rvalid_i = 1'b0;
        chk("r1_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        chk("r1_rsp_rdata", rsp_rdata_o, 32'h1234_5678);
        chk("r1_rsp_resp", {30'd0, rsp_resp_o}, 32'd0);
        chk("r1_rsp_write", {31'd0, rsp_write_o}, 32'd0);
        chk("r1_rready_drop", {31'd0, rready_o}, 32'd0);
        finish_rsp("r1");

        // Read with wrong RID -> SLVERR
        arready_i = 1'b1;
        issue(1'b0, 32'h0000_000C, 32'd0, 4'h0);
        tick();
        arready_i = 1'b0;
        rvalid_i = 1'b1; rdata_i = 32'hAAAA_5555; rresp_i = 2'b00; rid_i = 4'h5; rlast_i = 1'b1;
        tick();
        rvalid_i = 1'b0; rid_i = 4'h0;
        chk("r2_badid_resp", {30'd0, rsp_resp_o}, 32'd2);
        finish_rsp("r2");

        // Read with rlast low -> SLVERR
        arready_i = 1'b1;
        issue(1'b0, 32'h0000_0014, 32'd0, 4'h0);
        tick();
        arready_i = 1'b0;
        rvalid_i = 1'b1; rresp_i = 2'b01; rlast_i = 1'b0;
        tick();
        rvalid_i = 1'b0; rlast_i = 1'b1; rresp_i = 2'b00;
        chk("r3_nolast_resp", {30'd0, rsp_resp_o}, 32'd2);
        finish_rsp("r3");

        // Write with DECERR from slave, matching bid -> passed through
        awready_i = 1'b1; wready_i = 1'b1;
        issue(1'b1, 32'h0000_0018, 32'h5555_AAAA, 4'h1);
        tick();
        bvalid_i = 1'b1; bid_i = 4'h0; bresp_i = 2'b11;
        tick();
        bvalid_i = 1'b0;
        chk("w3_decerr_resp", {30'd0, rsp_resp_o}, 32'd3);
        finish_rsp("w3");

        // Write with wrong bid -> SLVERR
        issue(1'b1, 32'h0000_001C, 32'h0000_0001, 4'hF);
        tick();
        bvalid_i = 1'b1; bid_i = 4'h3; bresp_i = 2'b00;
        tick();
        bvalid_i = 1'b0; bid_i = 4'h0;
        chk("w4_badid_resp", {30'd0, rsp_resp_o}, 32'd2);
        finish_rsp("w4");

        // Response back-pressure for 10 cycles with a pending read command
        issue(1'b1, 32'h0000_0024, 32'h0F0F_0F0F, 4'hF);
        tick();
        awready_i = 1'b0; wready_i = 1'b0;
        bvalid_i = 1'b1; bresp_i = 2'b01;
        tick();
        bvalid_i = 1'b0; bresp_i = 2'b00;
        cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 32'h0000_0030;
        for (int i = 0; i < 10; i++) begin
            chk("bp_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
            chk("bp_rsp_fields", {28'd0, rsp_write_o, 1'b0, rsp_resp_o}, 32'h9);
            chk("bp_rsp_rdata", rsp_rdata_o, 32'd0);
            chk("bp_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
            tick();
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk("bp_release_idle", {30'd0, rsp_valid_o, arvalid_o}, 32'd0);
        chk("bp_release_ready", {31'd0, cmd_ready_o}, 32'd1);
        tick();
        cmd_valid_i = 1'b0;
        chk("bp_pending_accepted", {31'd0, arvalid_o}, 32'd1);
        chk("bp_pending_addr", araddr_o, 32'h0000_0030);
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        rvalid_i = 1'b1; rdata_i = 32'hCAFE_F00D; rid_i = 4'h0; rlast_i = 1'b1; rresp_i = 2'b00;
        tick();
        rvalid_i = 1'b0;
        chk("bp_read_rdata", rsp_rdata_o, 32'hCAFE_F00D);
        finish_rsp("bp");

        // Asynchronous reset while in WR_REQ
        issue(1'b1, 32'h0000_0040, 32'h1111_2222, 4'hF);
        chk("ar_in_wr_req", {30'd0, awvalid_o, wvalid_o}, 32'd3);
        #2;
        areset = 1'b0;
        #1;
        chk("ar_valids_cleared", {27'd0, awvalid_o, wvalid_o, arvalid_o, rsp_valid_o, bready_o}, 32'd0);
        chk("ar_awaddr_cleared", awaddr_o, 32'd0);
        chk("ar_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
        tick();
        areset = 1'b1;
        bvalid_i = 1'b1; bresp_i = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ar_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
        end
        bvalid_i = 1'b0;
        chk("ar_ready_again", {31'd0, cmd_ready_o}, 32'd1);
        awready_i = 1'b1; wready_i = 1'b1;
        issue(1'b1, 32'h0000_0020, 32'h0BAD_F00D, 4'hF);
        chk("ar_next_wdata", wdata_o, 32'h0BAD_F00D);
        tick();
        awready_i = 1'b0; wready_i = 1'b0;
        bvalid_i = 1'b1; bid_i = 4'h0; bresp_i = 2'b00;
        tick();
        bvalid_i = 1'b0;
        chk("ar_next_rsp", {29'd0, rsp_valid_o, rsp_resp_o}, 32'h4);
        finish_rsp("ar");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/m_axi_reg.md
M_AXI_REG -- requirements
Module: m_axi_reg

Interface
REQ-001 Parameter TXN_ID, 4'h0, constant ID driven on awid_o/wid_o/arid_o and expected on bid_i/rid_i.
REQ-002 clk  input  1  clock; all logic on posedge clk.
REQ-003 areset  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid_i  input  1  command request; cmd_ready_o  output  1  command accepted when both high.
REQ-005 cmd_write_i  input  1  1=write, 0=read; cmd_addr_i  input  32  byte address; cmd_wdata_i  input  32  write data; cmd_wstrb_i  input  4  byte strobes.
REQ-006 rsp_valid_o  output  1  result available; rsp_ready_i  input  1  result consumed when both high.
REQ-007 rsp_write_o  output  1  result is for a write; rsp_rdata_o  output  32  read data (0 for writes); rsp_resp_o  output  2  AXI response code.
REQ-008 awid_o 4, awaddr_o 32, awvalid_o 1 outputs; awready_i 1 input.
REQ-009 wid_o 4, wdata_o 32, wstrb_o 4, wlast_o 1, wvalid_o 1 outputs; wready_i 1 input.
REQ-010 bid_i 4, bresp_i 2, bvalid_i 1 inputs; bready_o 1 output.
REQ-011 arid_o 4, araddr_o 32, arvalid_o 1 outputs; arready_i 1 input.
REQ-012 rid_i 4, rdata_i 32, rresp_i 2, rlast_i 1, rvalid_i 1 inputs; rready_o 1 output.

Function
REQ-013 Block SHALL be a single-outstanding AXI initiator; every transaction single beat, wlast_o=1 whenever wvalid_o=1.
REQ-014 FSM states SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
REQ-015 cmd_ready_o SHALL be 1 only in IDLE; on accept, addr/wdata/wstrb/write SHALL be registered; next state WR_REQ or RD_REQ.
REQ-016 WR_REQ entry SHALL raise awvalid_o and wvalid_o in the same cycle (first cycle after accept).
REQ-017 awvalid_o SHALL drop the cycle after the AW handshake, and wvalid_o the cycle after the W handshake, independently; either order or the same cycle is legal.
REQ-018 Once asserted, awvalid_o/wvalid_o/arvalid_o and their payloads SHALL stay stable until handshake.
REQ-019 When both AW and W handshakes are complete, FSM SHALL enter WR_RESP with bready_o=1.
REQ-020 bvalid_i&&bready_o SHALL capture bresp_i and go to DONE; bready_o=0 outside WR_RESP.
REQ-021 RD_REQ SHALL hold arvalid_o=1 until arready_i, then enter RD_RESP with rready_o=1.
REQ-022 rvalid_i&&rready_o SHALL capture rdata_i/rresp_i and go to DONE; rready_o=0 outside RD_RESP.
REQ-023 If bid_i/rid_i != TXN_ID, or rlast_i=0 on the read beat, rsp_resp_o SHALL be 2'b10 (SLVERR) regardless of bresp_i/rresp_i.
REQ-024 DONE SHALL hold rsp_valid_o=1 and stable results until rsp_ready_i; then IDLE the next cycle.
REQ-025 A new command SHALL NOT be accepted in the cycle rsp_valid_o&&rsp_ready_i occurs (minimum 1 idle cycle).
REQ-026 Valid inputs (bvalid_i, rvalid_i) seen outside the corresponding RESP state SHALL be ignored.
REQ-027 Best-case latency: write accept to rsp_valid_o = 3 cycles (AW/W accepted on first cycle, B returned next cycle); read the same.

Reset
REQ-028 On areset low: FSM=IDLE; all valid/ready outputs 0 except none; cmd_ready_o 0 during reset, 1 the first cycle after release; all address/data/resp outputs 0; ID outputs = TXN_ID.
REQ-029 Reset mid-transaction SHALL abort immediately, with no rsp_valid_o for the aborted command.

Verification
REQ-030 Write 0x0000_0004 <- 0xDEAD_BEEF, strb 4'hF, AW/W ready immediately, bresp 0 -> awaddr/wdata match, rsp_valid_o 3 cycles after accept, rsp_resp_o 0, rsp_write_o 1.
REQ-031 wready_i delayed 5 cycles after awready_i -> awvalid_o drops after AW handshake, wvalid_o held 5 cycles with stable 0xDEAD_BEEF, bready_o only after W handshake.
REQ-032 Read 0x0000_0008, arready after 2 cycles, rdata 0x1234_5678, rresp 0, rid TXN_ID -> rsp_rdata_o 0x1234_5678, rsp_resp_o 0.
REQ-033 Read returning rid_i=4'h5 with TXN_ID=0 -> rsp_resp_o 2'b10; write with bresp 2'b11 and matching bid -> rsp_resp_o 2'b11.
REQ-034 rsp_ready_i held low 10 cycles -> rsp_valid_o and outputs stable, cmd_ready_o 0 throughout; command pending during release accepted one cycle after IDLE.
REQ-035 areset asserted while in WR_REQ -> all valids 0 asynchronously, no rsp_valid_o after release, next command completes normally.
